// File: rtl/control_pkg.sv
// Shared opcodes, FSM state encoding and instruction-field helper for the control unit.
package control_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVO  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;
    localparam logic [2:0] OP_LD   = 3'b110;
    localparam logic [2:0] OP_ST   = 3'b111;

    // Widest instruction: 16 registers -> 3 + 2*4 bits.
    localparam int IR_MAX_W = 11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_ALU    = 3'd2,
        S_WB     = 3'd3,
        S_MEM    = 3'd4
    } state_t;

    // Opcode sits in the top three bits of an instruction of width ir_w.
    function automatic logic [2:0] opcode_of(input logic [IR_MAX_W-1:0] ir, input int ir_w);
        return 3'(ir >> (ir_w - 3));
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control unit <-> datapath bundle: instruction/status in, datapath strobes out.
interface control_fsm_if #(
    parameter int NUM_REGS = 8
) ();
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam int IR_W  = 3 + 2 * SEL_W;

    logic                run;
    logic [IR_W-1:0]     ir;
    logic                g_zero;
    logic                mem_ready;

    logic                ain;
    logic                gin;
    logic                sub;
    logic [NUM_REGS-1:0] rin;
    logic [SEL_W-1:0]    rout;
    logic                din_en;
    logic                gout;
    logic                dout_en;
    logic                addr_en;
    logic                mem_wr;
    logic                ir_en;
    logic                done;
    logic                busy;

    modport master (
        input  run, ir, g_zero, mem_ready,
        output ain, gin, sub, rin, rout, din_en, gout, dout_en,
               addr_en, mem_wr, ir_en, done, busy
    );

    modport slave (
        output run, ir, g_zero, mem_ready,
        input  ain, gin, sub, rin, rout, din_en, gout, dout_en,
               addr_en, mem_wr, ir_en, done, busy
    );
endinterface

// File: rtl/control_decode.sv
// Purpose: combinational strobe decode from FSM state, instruction and status flags.
// Latency: zero cycles, outputs follow inputs within the same cycle.
// Backpressure: mem_ready gates the MEM-state load write and completion; no other stall.
module control_decode
    import control_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int IR_W     = 3 + 2 * SEL_W
) (
    input  state_t              state,
    input  logic [IR_W-1:0]     ir,
    input  logic                g_zero,
    input  logic                mem_ready,
    output logic                ain,
    output logic                gin,
    output logic                sub,
    output logic [NUM_REGS-1:0] rin,
    output logic [SEL_W-1:0]    rout,
    output logic                din_en,
    output logic                gout,
    output logic                dout_en,
    output logic                addr_en,
    output logic                mem_wr,
    output logic                done
);
    logic [2:0]       op;
    logic [SEL_W-1:0] rx;
    logic [SEL_W-1:0] ry;
    logic             rd_rx;
    logic             rd_ry;
    logic             wr_rx;
    logic             rx_ok;
    logic             ry_ok;

    assign op    = opcode_of(IR_MAX_W'(ir), IR_W);
    assign rx    = ir[2*SEL_W-1 -: SEL_W];
    assign ry    = ir[SEL_W-1:0];
    assign rx_ok = int'(rx) < NUM_REGS;
    assign ry_ok = int'(ry) < NUM_REGS;

    always_comb begin
        ain     = 1'b0;
        gin     = 1'b0;
        sub     = 1'b0;
        din_en  = 1'b0;
        gout    = 1'b0;
        dout_en = 1'b0;
        addr_en = 1'b0;
        mem_wr  = 1'b0;
        done    = 1'b0;
        rd_rx   = 1'b0;
        rd_ry   = 1'b0;
        wr_rx   = 1'b0;
        unique case (state)
            S_DECODE: begin
                unique case (op)
                    OP_MV:   begin rd_ry = 1'b1; wr_rx = 1'b1; done = 1'b1; end
                    OP_MVI:  begin din_en = 1'b1; wr_rx = 1'b1; done = 1'b1; end
                    OP_MVO:  begin rd_rx = 1'b1; dout_en = 1'b1; done = 1'b1; end
                    OP_MVNZ: begin rd_ry = 1'b1; wr_rx = ~g_zero; done = 1'b1; end
                    OP_ADD, OP_SUB: begin rd_rx = 1'b1; ain = 1'b1; end
                    default: begin rd_ry = 1'b1; addr_en = 1'b1; end
                endcase
            end
            S_ALU: begin
                rd_ry = 1'b1;
                gin   = 1'b1;
                sub   = (op == OP_SUB);
            end
            S_WB: begin
                gout  = 1'b1;
                wr_rx = 1'b1;
                done  = 1'b1;
            end
            S_MEM: begin
                // A store keeps the bus and write strobe steady for the whole wait.
                if (op == OP_ST) begin
                    rd_rx   = 1'b1;
                    dout_en = 1'b1;
                    mem_wr  = 1'b1;
                    done    = mem_ready;
                end else begin
                    din_en = mem_ready;
                    wr_rx  = mem_ready;
                    done   = mem_ready;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rin = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rin[i] = wr_rx && (int'(rx) == i);
        end
    end

    // Out-of-range selects leave the bus on register 0.
    always_comb begin
        rout = '0;
        if (rd_rx && rx_ok) begin
            rout = rx;
        end else if (rd_ry && ry_ok) begin
            rout = ry;
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Purpose: CPU control step sequencer; drives all datapath strobes from the instruction.
// Latency: 2 cycles for moves, 4 for ADD/SUB, 3+waits for LD/ST (FETCH to done inclusive).
// Backpressure: holds in MEM until mem_ready; run only sampled in FETCH.
module control_fsm
    import control_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int IR_W     = 3 + 2 * SEL_W
) (
    input  logic          clk,
    input  logic          resetn,
    control_fsm_if.master bus
);
    state_t              state_q;
    state_t              state_d;
    logic [2:0]          op;

    logic                ain_d;
    logic                gin_d;
    logic                sub_d;
    logic [NUM_REGS-1:0] rin_d;
    logic [SEL_W-1:0]    rout_d;
    logic                din_en_d;
    logic                gout_d;
    logic                dout_en_d;
    logic                addr_en_d;
    logic                mem_wr_d;
    logic                done_d;

    assign op = opcode_of(IR_MAX_W'(bus.ir), IR_W);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = bus.run ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op)
                    OP_ADD, OP_SUB: state_d = S_ALU;
                    OP_LD, OP_ST:   state_d = S_MEM;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_ALU:    state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_MEM:    state_d = bus.mem_ready ? S_FETCH : S_MEM;
            default:  state_d = S_FETCH;
        endcase
    end

    control_decode #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W),
        .IR_W     (IR_W)
    ) u_decode (
        .state     (state_q),
        .ir        (bus.ir),
        .g_zero    (bus.g_zero),
        .mem_ready (bus.mem_ready),
        .ain       (ain_d),
        .gin       (gin_d),
        .sub       (sub_d),
        .rin       (rin_d),
        .rout      (rout_d),
        .din_en    (din_en_d),
        .gout      (gout_d),
        .dout_en   (dout_en_d),
        .addr_en   (addr_en_d),
        .mem_wr    (mem_wr_d),
        .done      (done_d)
    );

    // Reset masks every strobe combinationally so nothing leaks while resetn is low.
    assign bus.ain     = resetn & ain_d;
    assign bus.gin     = resetn & gin_d;
    assign bus.sub     = resetn & sub_d;
    assign bus.rin     = resetn ? rin_d  : '0;
    assign bus.rout    = resetn ? rout_d : '0;
    assign bus.din_en  = resetn & din_en_d;
    assign bus.gout    = resetn & gout_d;
    assign bus.dout_en = resetn & dout_en_d;
    assign bus.addr_en = resetn & addr_en_d;
    assign bus.mem_wr  = resetn & mem_wr_d;
    assign bus.done    = resetn & done_d;
    assign bus.ir_en   = resetn & (state_q == S_FETCH) & bus.run;
    assign bus.busy    = resetn & (state_q != S_FETCH);

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: random instruction streams against a per-instruction timeline model.
module tb_control_fsm;

    localparam logic [2:0] T_MV = 3'b000, T_MVI = 3'b001, T_ADD = 3'b010, T_SUB = 3'b011;
    localparam logic [2:0] T_MVO = 3'b100, T_MVNZ = 3'b101, T_LD = 3'b110, T_ST = 3'b111;

    typedef struct packed {
        logic       ain;
        logic       gin;
        logic       sub;
        logic [7:0] rin;
        logic [2:0] rout;
        logic       din_en;
        logic       gout;
        logic       dout_en;
        logic       addr_en;
        logic       mem_wr;
        logic       ir_en;
        logic       done;
        logic       busy;
    } vec_t;

    logic clk;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    control_fsm_if #(.NUM_REGS(8)) if8 ();
    control_fsm_if #(.NUM_REGS(4)) if4 ();
    control_fsm_if #(.NUM_REGS(6)) if6 ();

    control_fsm #(.NUM_REGS(8)) dut8 (.clk(clk), .resetn(resetn), .bus(if8));
    control_fsm #(.NUM_REGS(4)) dut4 (.clk(clk), .resetn(resetn), .bus(if4));
    control_fsm #(.NUM_REGS(6)) dut6 (.clk(clk), .resetn(resetn), .bus(if6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t obs8();
        return {if8.ain, if8.gin, if8.sub, if8.rin, if8.rout, if8.din_en, if8.gout,
                if8.dout_en, if8.addr_en, if8.mem_wr, if8.ir_en, if8.done, if8.busy};
    endfunction

    // Cycles from FETCH to done inclusive.
    function automatic int instr_len(input logic [2:0] op, input int nwait);
        if (op == T_ADD || op == T_SUB) return 4;
        if (op == T_LD || op == T_ST)   return 3 + nwait;
        return 2;
    endfunction

    // Expected strobes at a given step of an instruction; step 0 is the FETCH cycle.
    function automatic vec_t model(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                                   input int step, input int len, input logic gz);
        vec_t e;
        e = '0;
        if (step == 0) begin
            e.ir_en = 1'b1;
            return e;
        end
        e.busy = 1'b1;
        e.done = (step == len - 1);
        case (op)
            T_MV:   begin e.rout = ry; e.rin[rx] = 1'b1; end
            T_MVI:  begin e.din_en = 1'b1; e.rin[rx] = 1'b1; end
            T_MVO:  begin e.rout = rx; e.dout_en = 1'b1; end
            T_MVNZ: begin e.rout = ry; e.rin[rx] = !gz; end
            T_ADD, T_SUB: begin
                if (step == 1) begin e.rout = rx; e.ain = 1'b1; end
                else if (step == 2) begin e.rout = ry; e.gin = 1'b1; e.sub = (op == T_SUB); end
                else begin e.gout = 1'b1; e.rin[rx] = 1'b1; end
            end
            T_LD: begin
                if (step == 1) begin e.rout = ry; e.addr_en = 1'b1; end
                else if (e.done) begin e.din_en = 1'b1; e.rin[rx] = 1'b1; end
            end
            default: begin
                if (step == 1) begin e.rout = ry; e.addr_en = 1'b1; end
                else begin e.rout = rx; e.dout_en = 1'b1; e.mem_wr = 1'b1; end
            end
        endcase
        return e;
    endfunction

    // Drive one instruction on the 8-register unit and compare every cycle.
    task automatic run_instr(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                             input int nwait, input logic gz, input string tag);
        int   len;
        vec_t exp_v;
        vec_t got;
        len = instr_len(op, nwait);
        for (int step = 0; step < len; step++) begin
            @(negedge clk);
            if8.run    = (step == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if8.ir     = {op, rx, ry};
            if8.g_zero = gz;
            if ((op == T_LD || op == T_ST) && step >= 2) if8.mem_ready = (step == len - 1);
            else if8.mem_ready = 1'($urandom_range(0, 1));
            #1;
            exp_v = model(op, rx, ry, step, len, gz);
            got   = obs8();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL %s step %0d: got %h expected %h", tag, step, got, exp_v);
            end
        end
    endtask

    task automatic check_idle8(input string tag);
        vec_t got;
        got = obs8();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected 0", tag, got);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        if8.run       = 1'b1;
        if8.ir        = 9'($urandom);
        if8.mem_ready = 1'b1;
        #1 check_idle8("reset_outputs");
        @(negedge clk);
        resetn  = 1'b1;
        if8.run = 1'b0;
        #1 check_idle8("idle_fetch_0");
        @(negedge clk);
        #1 check_idle8("idle_fetch_1");
    endtask

    task automatic test_mvi();
        run_instr(T_MVI, 3'd3, 3'd0, 0, 1'b0, "mvi_r3");
    endtask

    task automatic test_sub();
        run_instr(T_SUB, 3'd2, 3'd5, 0, 1'b0, "sub_r2_r5");
    endtask

    task automatic test_mvnz();
        run_instr(T_MVNZ, 3'd1, 3'd0, 0, 1'b1, "mvnz_gz1");
        run_instr(T_MVNZ, 3'd1, 3'd0, 0, 1'b0, "mvnz_gz0");
    endtask

    task automatic test_st_wait();
        run_instr(T_ST, 3'd4, 3'd6, 3, 1'b0, "st_wait3");
        run_instr(T_LD, 3'd7, 3'd2, 2, 1'b0, "ld_wait2");
    endtask

    task automatic test_reset_mid();
        vec_t exp_v;
        vec_t got;
        for (int step = 0; step < 3; step++) begin
            @(negedge clk);
            if8.run       = (step == 0);
            if8.ir        = {T_ADD, 3'd1, 3'd2};
            if8.mem_ready = 1'b0;
            #1;
            exp_v = model(T_ADD, 3'd1, 3'd2, step, 4, 1'b0);
            got   = obs8();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL add_pre_reset step %0d: got %h expected %h", step, got, exp_v);
            end
        end
        #1 resetn = 1'b0;
        #1 check_idle8("reset_mid_alu");
        @(negedge clk);
        if8.run = 1'b1;
        #1 check_idle8("reset_hold_run");
        @(negedge clk);
        resetn  = 1'b1;
        if8.run = 1'b0;
        #1 check_idle8("post_reset_0");
        @(negedge clk);
        #1 check_idle8("post_reset_1");
        run_instr(T_MV, 3'd5, 3'd3, 0, 1'b0, "mv_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            run_instr(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 4), 1'($urandom_range(0, 1)), "random");
        end
        @(negedge clk);
        if8.run = 1'b0;
        #1 check_idle8("idle_after_stream");
    endtask

    task automatic test_ld_small();
        @(negedge clk);
        if4.run = 1'b1; if4.ir = 7'b110_11_01; if4.mem_ready = 1'b1;
        #1 checks++;
        if ({if4.ir_en, if4.busy, if4.done} !== 3'b100) begin
            errors++;
            $display("FAIL ld4_fetch: got %b expected 100", {if4.ir_en, if4.busy, if4.done});
        end
        @(negedge clk);
        if4.run = 1'b0;
        #1 checks++;
        if ({if4.addr_en, if4.rout, if4.rin, if4.done, if4.busy} !== {1'b1, 2'd1, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ld4_decode: got %b expected 1010000 01",
                     {if4.addr_en, if4.rout, if4.rin, if4.done, if4.busy});
        end
        @(negedge clk);
        #1 checks++;
        if ({if4.din_en, if4.rin, if4.done, if4.busy, if4.mem_wr} !== {1'b1, 4'b1000, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ld4_mem: got %b expected 1100011 0",
                     {if4.din_en, if4.rin, if4.done, if4.busy, if4.mem_wr});
        end
        @(negedge clk);
        #1 checks++;
        if ({if4.busy, if4.done, if4.rin} !== 6'b0) begin
            errors++;
            $display("FAIL ld4_end: got %b expected 000000", {if4.busy, if4.done, if4.rin});
        end
    endtask

    task automatic test_out_of_range();
        logic [8:0] prog [2];
        prog[0] = 9'b000_111_110;
        prog[1] = 9'b100_111_000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if6.run = 1'b1; if6.ir = prog[k];
            #1 checks++;
            if (if6.ir_en !== 1'b1) begin
                errors++;
                $display("FAIL oob_fetch %0d: got ir_en=%b expected 1", k, if6.ir_en);
            end
            @(negedge clk);
            if6.run = 1'b0;
            #1 checks++;
            if ({if6.rout, if6.rin, if6.done, if6.busy, if6.dout_en} !== {3'd0, 6'd0, 1'b1, 1'b1, k == 1}) begin
                errors++;
                $display("FAIL oob_decode %0d: got rout=%0d rin=%b done=%b busy=%b dout_en=%b",
                         k, if6.rout, if6.rin, if6.done, if6.busy, if6.dout_en);
            end
        end
        @(negedge clk);
        #1 checks++;
        if (if6.busy !== 1'b0) begin
            errors++;
            $display("FAIL oob_end: got busy=%b expected 0", if6.busy);
        end
    endtask

    initial begin
        resetn = 1'b0;
        if8.run = 1'b0; if8.ir = '0; if8.g_zero = 1'b0; if8.mem_ready = 1'b0;
        if4.run = 1'b0; if4.ir = '0; if4.g_zero = 1'b0; if4.mem_ready = 1'b0;
        if6.run = 1'b0; if6.ir = '0; if6.g_zero = 1'b0; if6.mem_ready = 1'b0;

        test_reset();
        test_mvi();
        test_sub();
        test_mvnz();
        test_st_wait();
        test_reset_mid();
        test_back_to_back();
        test_ld_small();
        test_out_of_range();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
